conv2_maxpool: RTL and testbench



---
 rtl/conv2_maxpool.sv | 105 ++++++++++
 tb/tb_conv2_maxpool.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/conv2_maxpool.sv
// 2x2 stride-2 binary max-pool (per-channel OR) over a raster pixel stream.
// Odd trailing row/column are dropped; outputs are fully registered.
module conv2_maxpool #(
    parameter int WIDTH  = 11,
    parameter int HEIGHT = 11,
    parameter int CH     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] pixel_in,
    input  logic          valid_in,
    output logic [CH-1:0] pool_out,
    output logic          valid_out,
    output logic          frame_done
);

    localparam int OW = WIDTH / 2;
    localparam int OH = HEIGHT / 2;
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int IW = (OW > 1) ? $clog2(OW) : 1;

    logic [CW-1:0] col_cnt_reg, col_cnt_next;
    logic [RW-1:0] row_cnt_reg, row_cnt_next;
    logic [CH-1:0] hold_reg;
    logic [CH-1:0] rd_reg;
    logic [CH-1:0] pool_reg;
    logic          valid_reg;
    logic          done_reg;
    logic [CH-1:0] line_buf_reg [OW];

    logic          col_last, row_last;
    logic          col_in, row_in;
    logic          col_odd, row_odd;
    logic          hold_en, lb_we, pool_en;
    logic [IW-1:0] lb_idx;
    logic [OW-1:0] lb_sel;

    always_comb begin
        col_last = (col_cnt_reg == CW'(WIDTH - 1));
        row_last = (row_cnt_reg == RW'(HEIGHT - 1));
        col_in   = (int'(col_cnt_reg) < 2 * OW);
        row_in   = (int'(row_cnt_reg) < 2 * OH);
        col_odd  = col_cnt_reg[0];
        row_odd  = row_cnt_reg[0];
        lb_idx   = IW'(col_cnt_reg >> 1);
        hold_en  = valid_in & col_in & ~col_odd;
        lb_we    = valid_in & col_in & col_odd & row_in & ~row_odd;
        pool_en  = valid_in & col_in & col_odd & row_in & row_odd;

        col_cnt_next = col_cnt_reg;
        row_cnt_next = row_cnt_reg;
        if (valid_in) begin
            if (col_last) begin
                col_cnt_next = '0;
                row_cnt_next = row_last ? '0 : row_cnt_reg + 1'b1;
            end else begin
                col_cnt_next = col_cnt_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < OW; gi++) begin : g_lb_sel
        assign lb_sel[gi] = lb_we && (lb_idx == IW'(gi));
    end

    // The line-buffer entry needed at an odd column is fetched when its even
    // partner is accepted, so the pooling OR sees a registered read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
            hold_reg    <= '0;
            rd_reg      <= '0;
            pool_reg    <= '0;
            valid_reg   <= 1'b0;
            done_reg    <= 1'b0;
            for (int i = 0; i < OW; i++) begin
                line_buf_reg[i] <= '0;
            end
        end else begin
            col_cnt_reg <= col_cnt_next;
            row_cnt_reg <= row_cnt_next;
            if (hold_en) begin
                hold_reg <= pixel_in;
                rd_reg   <= line_buf_reg[lb_idx];
            end
            for (int i = 0; i < OW; i++) begin
                if (lb_sel[i]) begin
                    line_buf_reg[i] <= hold_reg | pixel_in;
                end
            end
            valid_reg <= pool_en;
            if (pool_en) begin
                pool_reg <= hold_reg | pixel_in | rd_reg;
            end
            done_reg <= valid_in & col_last & row_last;
        end
    end

    assign pool_out   = pool_reg;
    assign valid_out  = valid_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_conv2_maxpool.sv
// Directed bench for conv2_maxpool: pooled outputs checked against hand values
// and a reference OR-pool of the frames the bench itself drives.
module tb_conv2_maxpool;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pixel_in = '0;
    logic        valid_in = 1'b0;
    logic [15:0] pool_out;
    logic        valid_out;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    logic [15:0] img [2][11][11];
    logic [15:0] out_q [$];
    int          fd_cnt = 0;

    conv2_maxpool #(.WIDTH(11), .HEIGHT(11), .CH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_in   (pixel_in),
        .valid_in   (valid_in),
        .pool_out   (pool_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out === 1'b1) out_q.push_back(pool_out);
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int f, input int r, input int c);
        return img[f][2*r][2*c] | img[f][2*r][2*c+1] |
               img[f][2*r+1][2*c] | img[f][2*r+1][2*c+1];
    endfunction

    task automatic fill(input int f, input bit rnd);
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++)
                img[f][r][c] = rnd ? 16'($urandom) : 16'h0000;
    endtask

    task automatic send_frame(input int f, input int duty, input bit keep, input int npix);
        int n = 0;
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 11; c++) begin
                if (n < npix) begin
                    while (duty < 100 && int'($urandom_range(99, 0)) >= duty) begin
                        valid_in = 1'b0;
                        pixel_in = 16'($urandom);
                        @(negedge clk);
                    end
                    valid_in = 1'b1;
                    pixel_in = img[f][r][c];
                    @(negedge clk);
                    n++;
                end
            end
        end
        if (npix == 121) chk("frame_done_after_last", 32'(frame_done), 32'd1);
        if (!keep) valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int f, input int base);
        for (int i = 0; i < 25; i++)
            chk(tag, 32'(out_q[base + i]), 32'(model(f, i / 5, i % 5)));
    endtask

    task automatic clear_mon();
        out_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        // reset with valid_in asserted: reset must win
        rst_n = 1'b0; valid_in = 1'b1; pixel_in = 16'hffff;
        repeat (3) @(negedge clk);
        chk("rst_pool_out", 32'(pool_out), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        idle(3);
        chk("rst_no_outputs", out_q.size(), 32'd0);
        clear_mon();

        // all-zero contiguous frame
        fill(0, 1'b0);
        send_frame(0, 100, 1'b0, 121);
        idle(5);
        chk("zero_count", out_q.size(), 32'd25);
        chk("zero_frame_done_cnt", 32'(fd_cnt), 32'd1);
        for (int i = 0; i < 25; i++) chk("zero_value", 32'(out_q[i]), 32'h0);
        clear_mon();

        // single 1 on channel 0 at (3,4) -> output index 7
        fill(0, 1'b0);
        img[0][3][4] = 16'h0001;
        send_frame(0, 100, 1'b0, 121);
        idle(4);
        chk("single_count", out_q.size(), 32'd25);
        for (int i = 0; i < 25; i++)
            chk("single_value", 32'(out_q[i]), (i == 7) ? 32'h0001 : 32'h0);
        clear_mon();

        // each pixel of window (1,1) on channel 15
        for (int k = 0; k < 4; k++) begin
            fill(0, 1'b0);
            img[0][2 + k / 2][2 + k % 2] = 16'h8000;
            send_frame(0, 100, 1'b0, 121);
            idle(4);
            chk("sweep_count", out_q.size(), 32'd25);
            for (int i = 0; i < 25; i++)
                chk("sweep_value", 32'(out_q[i]), (i == 6) ? 32'h8000 : 32'h0);
            clear_mon();
        end

        // ones only in col 10 and row 10, then a zero frame back-to-back
        fill(0, 1'b0);
        for (int j = 0; j < 11; j++) begin
            img[0][10][j] = 16'hffff;
            img[0][j][10] = 16'hffff;
        end
        fill(1, 1'b0);
        send_frame(0, 100, 1'b1, 121);
        send_frame(1, 100, 1'b0, 121);
        idle(4);
        chk("discard_count", out_q.size(), 32'd50);
        chk("discard_frame_done_cnt", 32'(fd_cnt), 32'd2);
        for (int i = 0; i < 50; i++) chk("discard_value", 32'(out_q[i]), 32'h0);
        clear_mon();

        // random frames with random valid gaps
        fill(0, 1'b1);
        fill(1, 1'b1);
        send_frame(0, int'($urandom_range(70, 30)), 1'b1, 121);
        send_frame(1, int'($urandom_range(70, 30)), 1'b0, 121);
        idle(4);
        chk("gap_count", out_q.size(), 32'd50);
        chk("gap_frame_done_cnt", 32'(fd_cnt), 32'd2);
        check_out("gap_frame0", 0, 0);
        check_out("gap_frame1", 1, 25);
        clear_mon();

        // random frames back-to-back, no idle cycle
        fill(0, 1'b1);
        fill(1, 1'b1);
        send_frame(0, 100, 1'b1, 121);
        send_frame(1, 100, 1'b0, 121);
        idle(4);
        chk("b2b_count", out_q.size(), 32'd50);
        check_out("b2b_frame0", 0, 0);
        check_out("b2b_frame1", 1, 25);
        clear_mon();

        // reset after 60 accepted pixels, then a fresh frame
        fill(0, 1'b1);
        send_frame(0, 100, 1'b1, 60);
        clear_mon();
        rst_n = 1'b0; valid_in = 1'b1; pixel_in = 16'hffff;
        @(negedge clk);
        chk("midrst_pool_out", 32'(pool_out), 32'd0);
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        rst_n = 1'b1;
        idle(3);
        chk("midrst_no_outputs", out_q.size(), 32'd0);
        chk("midrst_no_frame_done", 32'(fd_cnt), 32'd0);
        fill(1, 1'b1);
        send_frame(1, 100, 1'b0, 121);
        idle(4);
        chk("midrst_count", out_q.size(), 32'd25);
        chk("midrst_frame_done_cnt", 32'(fd_cnt), 32'd1);
        check_out("midrst_frame", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
